// File: rtl/rs_arbiter_if.sv
// Signal bundle between the RS arbiter, the two deinterleaver streams and the shared RS decoder.
interface rs_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ts0_rs_req;
    logic [1:0]       ts0_rs_mode;
    logic             ts0_rs_en_in;
    logic [7:0]       ts0_rs_din;
    logic             ts0_rs_gnt;
    logic             ts0_rs_en_out;
    logic [7:0]       ts0_rs_dout;
    logic             ts0_rs_done;
    logic             ts0_rs_fail;
    logic [CNT_W-1:0] ts0_fail_cnt;

    logic             ts1_rs_req;
    logic [1:0]       ts1_rs_mode;
    logic             ts1_rs_en_in;
    logic [7:0]       ts1_rs_din;
    logic             ts1_rs_gnt;
    logic             ts1_rs_en_out;
    logic [7:0]       ts1_rs_dout;
    logic             ts1_rs_done;
    logic             ts1_rs_fail;
    logic [CNT_W-1:0] ts1_fail_cnt;

    logic [1:0]       rs_mode;
    logic             rs_en_in;
    logic [7:0]       rs_din;
    logic             rs_en_out;
    logic [7:0]       rs_dout;
    logic             rs_row_finish;
    logic             rs_cor_fail;
    logic             rs_timeout;

    // Streams and decoder side
    modport master (
        output ts0_rs_req, ts0_rs_mode, ts0_rs_en_in, ts0_rs_din,
        output ts1_rs_req, ts1_rs_mode, ts1_rs_en_in, ts1_rs_din,
        input  ts0_rs_gnt, ts0_rs_en_out, ts0_rs_dout, ts0_rs_done, ts0_rs_fail, ts0_fail_cnt,
        input  ts1_rs_gnt, ts1_rs_en_out, ts1_rs_dout, ts1_rs_done, ts1_rs_fail, ts1_fail_cnt,
        input  rs_mode, rs_en_in, rs_din, rs_timeout,
        output rs_en_out, rs_dout, rs_row_finish, rs_cor_fail
    );

    // Arbiter side
    modport slave (
        input  ts0_rs_req, ts0_rs_mode, ts0_rs_en_in, ts0_rs_din,
        input  ts1_rs_req, ts1_rs_mode, ts1_rs_en_in, ts1_rs_din,
        output ts0_rs_gnt, ts0_rs_en_out, ts0_rs_dout, ts0_rs_done, ts0_rs_fail, ts0_fail_cnt,
        output ts1_rs_gnt, ts1_rs_en_out, ts1_rs_dout, ts1_rs_done, ts1_rs_fail, ts1_fail_cnt,
        output rs_mode, rs_en_in, rs_din, rs_timeout,
        input  rs_en_out, rs_dout, rs_row_finish, rs_cor_fail
    );
endinterface

// File: rtl/rs_arbiter.sv
// Round-robin owner arbitration of the shared RS decoder between ts0 and ts1,
// with per-stream failure counters and a stuck-row watchdog.
module rs_arbiter #(
    parameter int unsigned TIMEOUT = 4095,
    parameter int unsigned CNT_W   = 16
) (
    input logic         clk,
    input logic         reset,
    rs_arbiter_if.slave bus
);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_owner_q;
    logic [WD_W-1:0]  wd_q;
    logic [1:0]       mode_q;
    logic             done0_q, done1_q, fail0_q, fail1_q, tmo_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    logic own0, own1, own_req, wd_hit;
    logic done0_d, done1_d, fail_d, tmo_d;

    assign own0    = (state_q == OWN0);
    assign own1    = (state_q == OWN1);
    assign own_req = own0 ? bus.ts0_rs_req : bus.ts1_rs_req;
    assign wd_hit  = (wd_q == WD_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: ts0 wins when alone or when ts1 owned last
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ts0_rs_req && (!bus.ts1_rs_req || last_owner_q)) state_d = OWN0;
                else if (bus.ts1_rs_req)                                 state_d = OWN1;
            end
            OWN0, OWN1: begin
                if (bus.rs_row_finish || wd_hit || !own_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Row completion outcome; finish outranks watchdog, abort produces nothing
    always_comb begin
        done0_d = 1'b0;
        done1_d = 1'b0;
        fail_d  = 1'b0;
        tmo_d   = 1'b0;
        if (own0 || own1) begin
            if (bus.rs_row_finish) begin
                done0_d = own0;
                done1_d = own1;
                fail_d  = bus.rs_cor_fail;
            end else if (wd_hit) begin
                done0_d = own0;
                done1_d = own1;
                fail_d  = 1'b1;
                tmo_d   = 1'b1;
            end
        end
    end

    // Registered outputs, mode latch, watchdog and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= 1'b1;
            wd_q         <= '0;
            mode_q       <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            fail0_q      <= 1'b0;
            fail1_q      <= 1'b0;
            tmo_q        <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            done0_q <= done0_d;
            done1_q <= done1_d;
            fail0_q <= done0_d & fail_d;
            fail1_q <= done1_d & fail_d;
            tmo_q   <= tmo_d;
            if (done0_d && fail_d && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
            if (done1_d && fail_d && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);

            if (state_q == IDLE) begin
                wd_q <= '0;
                if (state_d == OWN0)      mode_q <= bus.ts0_rs_mode;
                else if (state_d == OWN1) mode_q <= bus.ts1_rs_mode;
            end else if (state_d == IDLE) begin
                wd_q         <= '0;
                mode_q       <= '0;
                last_owner_q <= own1;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
        end
    end

    // Return path, visible to the owner only
    assign bus.ts0_rs_gnt    = own0;
    assign bus.ts0_rs_en_out = bus.rs_en_out & own0;
    assign bus.ts0_rs_dout   = own0 ? bus.rs_dout : 8'h00;
    assign bus.ts0_rs_done   = done0_q;
    assign bus.ts0_rs_fail   = fail0_q;
    assign bus.ts0_fail_cnt  = cnt0_q;

    assign bus.ts1_rs_gnt    = own1;
    assign bus.ts1_rs_en_out = bus.rs_en_out & own1;
    assign bus.ts1_rs_dout   = own1 ? bus.rs_dout : 8'h00;
    assign bus.ts1_rs_done   = done1_q;
    assign bus.ts1_rs_fail   = fail1_q;
    assign bus.ts1_fail_cnt  = cnt1_q;

    // Forward path, driven by the owner only
    assign bus.rs_mode    = mode_q;
    assign bus.rs_en_in   = (bus.ts0_rs_en_in & own0) | (bus.ts1_rs_en_in & own1);
    assign bus.rs_din     = own0 ? bus.ts0_rs_din : (own1 ? bus.ts1_rs_din : 8'h00);
    assign bus.rs_timeout = tmo_q;
endmodule

// File: tb/tb_rs_arbiter.sv
// Scoreboard bench for rs_arbiter: stimulus queues expected grants/row completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_rs_arbiter;
    localparam int unsigned TO   = 24;
    localparam int unsigned CW   = 2;
    localparam int          MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  stream;
        logic [7:0]  mode;
    } gnt_exp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  stream;
        logic [7:0]  fail;
        logic [7:0]  tmo;
        logic [7:0]  cnt;
    } done_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   exp_cnt [2];
    logic pg0 = 1'b0;
    logic pg1 = 1'b0;
    gnt_exp_t  gnt_q [$];
    done_exp_t done_q [$];

    rs_arbiter_if #(.CNT_W(CW)) b ();

    rs_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input int c, input int s, input logic [1:0] m);
        gnt_q.push_back('{cyc: 32'(c), stream: 8'(s), mode: 8'(m)});
    endtask

    task automatic expect_done(input int c, input int s, input bit f, input bit t);
        if (f && exp_cnt[s] < MAXC) exp_cnt[s]++;
        done_q.push_back('{cyc: 32'(c), stream: 8'(s), fail: 8'(f), tmo: 8'(t), cnt: 8'(exp_cnt[s])});
    endtask

    // One-cycle decoder finish; s < 0 means no completion is expected
    task automatic finish_row(input int s, input bit f);
        b.rs_row_finish = 1'b1;
        b.rs_cor_fail   = f;
        if (s >= 0) expect_done(cyc + 1, s, f, 1'b0);
        tick();
        b.rs_row_finish = 1'b0;
        b.rs_cor_fail   = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {b.ts0_rs_gnt, b.ts1_rs_gnt, b.ts0_rs_done, b.ts1_rs_done,
                     b.ts0_rs_fail, b.ts1_rs_fail, b.rs_timeout, b.rs_mode, b.rs_en_in,
                     b.rs_din, b.ts0_fail_cnt, b.ts1_fail_cnt, b.ts0_rs_dout, b.ts1_rs_dout}, 64'd0);
    endtask

    task automatic gnt_event(input int s);
        gnt_exp_t e;
        if (gnt_q.size() == 0) begin
            check("gnt_unexpected", 64'(s + 1), 64'd0);
        end else begin
            e = gnt_q.pop_front();
            check("gnt", {32'(cyc), 8'(s), 8'(b.rs_mode)}, {e.cyc, e.stream, e.mode});
        end
    endtask

    task automatic done_event(input int s, input logic f, input logic [CW-1:0] c);
        done_exp_t e;
        if (done_q.size() == 0) begin
            check("done_unexpected", 64'(s + 1), 64'd0);
        end else begin
            e = done_q.pop_front();
            check("done", {32'(cyc), 8'(s), 8'(f), 8'(b.rs_timeout), 8'(c)},
                  {e.cyc, e.stream, e.fail, e.tmo, e.cnt});
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (b.ts0_rs_gnt && !pg0) gnt_event(0);
            if (b.ts1_rs_gnt && !pg1) gnt_event(1);
            if (b.ts0_rs_gnt && b.ts1_rs_gnt) check("dual_gnt", 64'd1, 64'd0);
            if (b.ts0_rs_done) done_event(0, b.ts0_rs_fail, b.ts0_fail_cnt);
            if (b.ts1_rs_done) done_event(1, b.ts1_rs_fail, b.ts1_fail_cnt);
            if (b.rs_timeout && !b.ts0_rs_done && !b.ts1_rs_done)
                check("stray_timeout", 64'(b.rs_timeout), 64'd0);
        end
        pg0 = b.ts0_rs_gnt;
        pg1 = b.ts1_rs_gnt;
    end

    int g;

    initial begin
        exp_cnt = '{0, 0};
        {b.ts0_rs_req, b.ts0_rs_mode, b.ts0_rs_en_in, b.ts0_rs_din} = '0;
        {b.ts1_rs_req, b.ts1_rs_mode, b.ts1_rs_en_in, b.ts1_rs_din} = '0;
        {b.rs_en_out, b.rs_dout, b.rs_row_finish, b.rs_cor_fail} = '0;
        repeat (2) tick();
        check_all_zero("reset_state");
        reset = 1'b0;
        tick();

        // Single request, ten bytes, clean finish; ts1 noise must never reach the decoder
        b.ts0_rs_req  = 1'b1;
        b.ts0_rs_mode = 2'b10;
        expect_gnt(cyc + 1, 0, 2'b10);
        tick();
        b.ts1_rs_en_in = 1'b1;
        b.ts1_rs_din   = 8'hA5;
        b.rs_dout      = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            b.ts0_rs_en_in = 1'b1;
            b.ts0_rs_din   = 8'(8'h10 + i);
            b.rs_en_out    = (i % 3 == 0);
            #1;
            check("fwd_byte", {b.rs_en_in, b.rs_din}, {1'b1, 8'(8'h10 + i)});
            if (i % 3 == 0)
                check("ret_route", {b.ts0_rs_en_out, b.ts0_rs_dout, b.ts1_rs_en_out, b.ts1_rs_dout},
                      {1'b1, 8'h3C, 1'b0, 8'h00});
            tick();
        end
        b.rs_en_out    = 1'b0;
        b.ts0_rs_en_in = 1'b0;
        finish_row(0, 1'b0);
        check("gnt_after_done", {b.ts0_rs_gnt, b.ts1_rs_gnt}, 64'd0);
        b.ts0_rs_req   = 1'b0;
        b.ts0_rs_en_in = 1'b1;
        b.ts0_rs_din   = 8'h77;
        #1;
        check("idle_fwd_drop", {b.rs_en_in, b.rs_din, b.rs_mode}, 64'd0);
        b.ts0_rs_en_in = 1'b0;
        b.ts1_rs_en_in = 1'b0;
        b.ts1_rs_din   = 8'h00;
        tick();

        // Tie after reset, then strict alternation with ts0 re-requesting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = '{0, 0};
        b.ts0_rs_req  = 1'b1;
        b.ts0_rs_mode = 2'b01;
        b.ts1_rs_req  = 1'b1;
        b.ts1_rs_mode = 2'b11;
        expect_gnt(cyc + 1, 0, 2'b01);
        tick();
        tick();
        expect_gnt(cyc + 2, 1, 2'b11);
        finish_row(0, 1'b1);
        repeat (3) tick();
        expect_gnt(cyc + 2, 0, 2'b01);
        finish_row(1, 1'b1);
        b.ts1_rs_req = 1'b0;
        tick();
        tick();
        finish_row(0, 1'b1);
        b.ts0_rs_req = 1'b0;
        tick();

        // Stray finish and decoder output while idle
        b.rs_row_finish = 1'b1;
        b.rs_cor_fail   = 1'b1;
        b.rs_en_out     = 1'b1;
        #1;
        check("idle_ret_drop", {b.ts0_rs_en_out, b.ts1_rs_en_out, b.ts0_rs_dout, b.ts1_rs_dout}, 64'd0);
        tick();
        b.rs_row_finish = 1'b0;
        b.rs_cor_fail   = 1'b0;
        b.rs_en_out     = 1'b0;
        tick();
        check("stray_cnt", 64'(b.ts0_fail_cnt), 64'(exp_cnt[0]));

        // Two more failed rows on ts0: counter reaches 3 and saturates
        repeat (2) begin
            b.ts0_rs_req  = 1'b1;
            b.ts0_rs_mode = 2'b10;
            expect_gnt(cyc + 1, 0, 2'b10);
            tick();
            tick();
            finish_row(0, 1'b1);
            b.ts0_rs_req = 1'b0;
            tick();
        end
        check("sat_cnt", 64'(b.ts0_fail_cnt), 64'(MAXC));

        // Watchdog on ts1 while ts0 waits
        b.ts1_rs_req  = 1'b1;
        b.ts1_rs_mode = 2'b10;
        expect_gnt(cyc + 1, 1, 2'b10);
        tick();
        g = cyc;
        b.ts0_rs_req  = 1'b1;
        b.ts0_rs_mode = 2'b00;
        expect_done(g + TO, 1, 1'b1, 1'b1);
        expect_gnt(g + TO + 1, 0, 2'b00);
        repeat (TO) tick();
        b.ts1_rs_req = 1'b0;
        tick();

        // Abort by ts0, then by ts1: grant drops, no completion
        tick();
        b.ts0_rs_req = 1'b0;
        tick();
        check("abort0", {b.ts0_rs_gnt, b.ts0_rs_done}, 64'd0);
        tick();
        b.ts1_rs_req  = 1'b1;
        b.ts1_rs_mode = 2'b01;
        expect_gnt(cyc + 1, 1, 2'b01);
        tick();
        tick();
        b.ts1_rs_req = 1'b0;
        tick();
        check("abort1", {b.ts1_rs_gnt, b.ts1_rs_done, b.ts1_fail_cnt}, {1'b0, 1'b0, CW'(exp_cnt[1])});
        tick();

        // Reset in the middle of a ts0 grant with ts1 pending
        b.ts0_rs_req  = 1'b1;
        b.ts0_rs_mode = 2'b11;
        expect_gnt(cyc + 1, 0, 2'b11);
        tick();
        b.ts1_rs_req   = 1'b1;
        b.ts1_rs_mode  = 2'b01;
        b.ts0_rs_en_in = 1'b1;
        b.ts0_rs_din   = 8'h5A;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        b.ts0_rs_en_in = 1'b0;
        exp_cnt = '{0, 0};
        expect_gnt(cyc + 1, 0, 2'b11);
        tick();
        expect_gnt(cyc + 2, 1, 2'b01);
        finish_row(0, 1'b0);
        b.ts0_rs_req = 1'b0;
        tick();
        finish_row(1, 1'b0);
        b.ts1_rs_req = 1'b0;
        repeat (3) tick();

        check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
